// File: rtl/key_cmp_pkg.sv
// Shared encodings and defaults for the debounced key comparator.
package key_cmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    localparam int unsigned DB_CNT_MAX = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a whole-vector debounce filter.
module key_debounce
    import key_cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CNT_MAX = DB_CNT_MAX
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned       CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_db;
    logic [CNT_W-1:0] r_cnt;

    // r_s1 != r_s2 means s2 moves on this edge, so the stability window restarts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_db  <= '0;
            r_cnt <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            if (r_s1 != r_s2) begin
                r_cnt <= '0;
            end else if (r_s2 != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_db;

endmodule

// File: rtl/key_cmp_db.sv
// Debounces two key buses and registers a one-hot unsigned/signed compare with change pulse.
module key_cmp_db
    import key_cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CNT_MAX = DB_CNT_MAX
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] a_db,
    output logic [WIDTH-1:0] b_db,
    output logic [2:0]       c,
    output logic             c_vld
);

    logic [WIDTH-1:0] w_a_db;
    logic [WIDTH-1:0] w_b_db;
    logic             w_gt;
    logic             w_lt;
    logic [2:0]       w_c_next;
    logic [2:0]       r_c;
    logic             r_c_vld;

    key_debounce #(
        .WIDTH   (WIDTH),
        .CNT_MAX (CNT_MAX)
    ) u_db_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (a),
        .dout      (w_a_db)
    );

    key_debounce #(
        .WIDTH   (WIDTH),
        .CNT_MAX (CNT_MAX)
    ) u_db_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (b),
        .dout      (w_b_db)
    );

    always_comb begin
        w_gt     = 1'b0;
        w_lt     = 1'b0;
        w_c_next = CMP_EQ;
        if (signed_mode) begin
            w_gt = $signed(w_a_db) > $signed(w_b_db);
            w_lt = $signed(w_a_db) < $signed(w_b_db);
        end else begin
            w_gt = w_a_db > w_b_db;
            w_lt = w_a_db < w_b_db;
        end
        if (w_gt) begin
            w_c_next = CMP_GT;
        end else if (w_lt) begin
            w_c_next = CMP_LT;
        end
    end

    // c_vld is registered alongside c so it is high in the same cycle c shows its new value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_c     <= CMP_EQ;
            r_c_vld <= 1'b0;
        end else begin
            r_c     <= w_c_next;
            r_c_vld <= (w_c_next != r_c);
        end
    end

    assign a_db  = w_a_db;
    assign b_db  = w_b_db;
    assign c     = r_c;
    assign c_vld = r_c_vld;

endmodule

// File: tb/tb_key_cmp_db.sv
// Directed bench for key_cmp_db with WIDTH=4, CNT_MAX=4.
module tb_key_cmp_db;

    localparam int unsigned W  = 4;
    localparam int unsigned CM = 4;

    logic         sys_clk     = 1'b0;
    logic         sys_rst_n   = 1'b0;
    logic [W-1:0] a           = '0;
    logic [W-1:0] b           = '0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] a_db;
    logic [W-1:0] b_db;
    logic [2:0]   c;
    logic         c_vld;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulse  = 0;

    always #5 sys_clk = ~sys_clk;

    key_cmp_db #(
        .WIDTH   (W),
        .CNT_MAX (CM)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .a_db        (a_db),
        .b_db        (b_db),
        .c           (c),
        .c_vld       (c_vld)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            if (c_vld === 1'b1) n_pulse++;
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1) begin
            n_checks++;
            assert ($onehot(c)) else begin
                n_errors++;
                $error("FAIL onehot: observed %b expected one-hot", c);
            end
        end
    end

    initial begin
        logic [W-1:0] cur;
        logic [W-1:0] g;
        logic         seen;

        // Reset state
        tick(3);
        sys_rst_n = 1'b1;
        check("rst_c", 32'(c), 32'h2);
        check("rst_vld", 32'(c_vld), 32'h0);
        check("rst_a_db", 32'(a_db), 32'h0);
        check("rst_b_db", 32'(b_db), 32'h0);
        n_pulse = 0;
        tick(20);
        check("rst_no_pulse", 32'(n_pulse), 32'h0);

        // Glitch of 3 cycles never reaches a_db
        n_pulse = 0;
        a = 4'h9;
        tick(3);
        a = 4'h0;
        tick(12);
        check("glitch_a_db", 32'(a_db), 32'h0);
        check("glitch_c", 32'(c), 32'h2);
        check("glitch_no_pulse", 32'(n_pulse), 32'h0);

        // a=5, b=3: db at k+5, c at k+6
        n_pulse = 0;
        a = 4'h5;
        b = 4'h3;
        tick(5);
        check("lat_a_db_early", 32'(a_db), 32'h0);
        tick(1);
        check("lat_a_db", 32'(a_db), 32'h5);
        check("lat_b_db", 32'(b_db), 32'h3);
        check("lat_c_early", 32'(c), 32'h2);
        tick(1);
        check("lat_c", 32'(c), 32'h4);
        check("lat_vld", 32'(c_vld), 32'h1);
        tick(1);
        check("lat_vld_drop", 32'(c_vld), 32'h0);
        check("lat_pulses", 32'(n_pulse), 32'h1);

        // F vs 1: unsigned GT, signed LT
        n_pulse = 0;
        a = 4'hF;
        b = 4'h1;
        tick(10);
        check("uns_c", 32'(c), 32'h4);
        check("uns_no_pulse", 32'(n_pulse), 32'h0);
        signed_mode = 1'b1;
        tick(1);
        check("sgn_c", 32'(c), 32'h1);
        check("sgn_vld", 32'(c_vld), 32'h1);
        tick(1);
        check("sgn_vld_drop", 32'(c_vld), 32'h0);
        signed_mode = 1'b0;
        tick(2);
        check("uns_back_c", 32'(c), 32'h4);

        // Simultaneous change 2/9 -> 7/7
        a = 4'h2;
        b = 4'h9;
        tick(10);
        check("sim_pre_c", 32'(c), 32'h1);
        n_pulse = 0;
        a = 4'h7;
        b = 4'h7;
        tick(6);
        check("sim_c_early", 32'(c), 32'h1);
        tick(1);
        check("sim_c", 32'(c), 32'h2);
        check("sim_vld", 32'(c_vld), 32'h1);
        tick(5);
        check("sim_pulses", 32'(n_pulse), 32'h1);

        // Reset two cycles into a debounce
        a = 4'h6;
        tick(2);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_a_db", 32'(a_db), 32'h0);
        check("mid_rst_b_db", 32'(b_db), 32'h0);
        check("mid_rst_c", 32'(c), 32'h2);
        check("mid_rst_vld", 32'(c_vld), 32'h0);
        tick(2);
        sys_rst_n = 1'b1;
        tick(5);
        check("post_rst_a_db_early", 32'(a_db), 32'h0);
        tick(1);
        check("post_rst_a_db", 32'(a_db), 32'h6);
        check("post_rst_b_db", 32'(b_db), 32'h7);
        tick(1);
        check("post_rst_c", 32'(c), 32'h1);

        // Bounce soak: a pulse reaches a_db only if held longer than CNT_MAX cycles
        cur = 4'h3;
        a   = cur;
        b   = 4'h8;
        tick(12);
        for (int len = 1; len <= 8; len++) begin
            if (len == int'(CM)) continue;
            g    = cur ^ 4'($urandom_range(1, 15));
            seen = 1'b0;
            a    = g;
            for (int i = 0; i < len; i++) begin
                tick(1);
                if (a_db == g) seen = 1'b1;
            end
            a = cur;
            for (int i = 0; i < 14; i++) begin
                tick(1);
                if (a_db == g) seen = 1'b1;
            end
            check($sformatf("soak_seen_len%0d", len), 32'(seen), 32'(len > int'(CM)));
            check($sformatf("soak_a_db_len%0d", len), 32'(a_db), 32'(cur));
            check($sformatf("soak_c_len%0d", len), 32'(c), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
